// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues imem reads at PC, captures word/PC/PC+4 into a
// one-entry slot for decode, and drives the PC register's advance enable.
module instr_fetch #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        Adv,
  input  logic        flush,
  input  logic        halt,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_npc
);

  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HALTED = 2'd2} state_t;

  state_t state;
  logic   accept;

  assign imemaddr = PC;

  // Issue only when the slot is empty or being drained this cycle, so the
  // captured word always has somewhere to go.
  assign imemREN = (state == FETCH) & ~halt & ~flush & (~if_valid | id_ready);
  assign accept  = imemREN & ihit;
  assign Adv     = accept | flush;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= PC_INIT;
      if_npc   <= PC_INIT + word_t'(4);
    end else begin
      case (state)
        IDLE:    state <= halt ? HALTED : FETCH;
        FETCH:   if (halt) state <= HALTED;
        default: state <= HALTED;
      endcase

      // A redirect wins over any data returning in the same cycle.
      if (flush) begin
        if_valid <= 1'b0;
      end else if (accept) begin
        if_valid <= 1'b1;
        if_instr <= imemload;
        if_pc    <= PC;
        if_npc   <= PC + word_t'(4);
      end else if (if_valid && id_ready) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly downstream of the PC register. It issues instruction-memory reads at the current PC and captures the returned word, PC and PC+4 into a one-entry fetch slot for decode. It drives the PC register's advance enable (`Adv`) so the PC moves only when a fetch is accepted or a redirect occurs. A sticky halt stops all further fetching.

## Interface
- `PC_INIT`, default `0`: value reported on `if_pc` and `if_npc` while the slot is empty after reset.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `PC` in 32 (`word_t`): current PC from the PC register.
- `imemREN` out 1: instruction read enable (level).
- `imemaddr` out 32: read address, always equal to `PC`.
- `ihit` in 1: read data valid this cycle.
- `imemload` in 32: instruction word from memory.
- `Adv` out 1: PC register advance enable.
- `flush` in 1: branch or jump redirect; discard the slot.
- `halt` in 1: halt seen downstream; stop fetching permanently.
- `id_ready` in 1: decode consumes the slot this cycle when `if_valid`=1.
- `if_valid` out 1: slot holds a valid instruction.
- `if_instr` out 32: captured instruction.
- `if_pc` out 32: PC of the captured instruction.
- `if_npc` out 32: `if_pc`+4.

## Operation
- FSM states:
  - IDLE: the reset state. Always moves to FETCH on the next edge, or to HALTED if `halt`=1.
  - FETCH: normal operation. Moves to HALTED when `halt`=1.
  - HALTED: terminal until `RST`.
- `imemREN` = (state==FETCH) & !`halt` & !`flush` & (!`if_valid` | `id_ready`). Fetch is issued only when the slot is empty or is being drained this cycle.
- Accept = `imemREN` & `ihit`.
- `Adv` = accept | `flush`. On `flush`, the upstream next-PC mux supplies the target and the PC register loads it.
- Slot update priority, highest first:
  1. `flush`: `if_valid`<=0. Any `ihit` data in that cycle is discarded.
  2. Accept: `if_instr`<=`imemload`, `if_pc`<=`PC`, `if_npc`<=`PC`+4 (mod 2^32, so 0xFFFFFFFC gives 0x00000000), `if_valid`<=1.
  3. `if_valid` & `id_ready`: `if_valid`<=0.
  4. Otherwise: hold.
- When the slot is full and `id_ready`=0, `imemREN`=0 and `Adv`=0; the PC holds.
- `ihit` while `imemREN`=0 is ignored.
- `halt`:
  - Blocks `imemREN` in the same cycle and enters HALTED.
  - The slot keeps its contents, so decode can still drain it.
  - `flush` still works in HALTED: it clears the slot and pulses `Adv`; the PC register's own Halt input blocks the PC update.
- `flush` and `halt` in the same cycle: the slot is cleared, `Adv`=1, and the state goes to HALTED.
- The stage is fully combinational from `PC` to `imemaddr`.

## Timing
- While `RST`=1: state IDLE, `if_valid`=0, `if_instr`=0, `if_pc`=`PC_INIT`, `if_npc`=`PC_INIT`+4. Combinationally `imemREN`=0, and `Adv`=`flush`.
- `RST` asserted mid-request drops `imemREN` immediately (asynchronous); the pending `ihit` is lost.
- First `imemREN` is in the first full cycle after `RST` deasserts, i.e. after one IDLE cycle.
- Fetch latency: `ihit` in cycle N gives `if_valid`=1 in cycle N+1, with `Adv`=1 in cycle N so the PC advances at the same edge.
- Throughput: 1 instruction per cycle when `ihit`=1 and `id_ready`=1 continuously.
- `imemREN` stays high across memory wait cycles (`ihit`=0) with a stable `imemaddr`.
- `flush` has zero-cycle effect on `imemREN` and `Adv`. The slot is empty in the following cycle, and fetch of the target starts that same following cycle.

## Test plan
- **Reset and stream:** `PC_INIT`=0. Release `RST`; memory returns `ihit`=1 every cycle; `id_ready`=1. Expect one IDLE cycle, then `Adv`=1 every cycle, and `if_pc` sequence 0, 4, 8 with `if_npc` sequence 4, 8, 12.
- **Memory wait:** `ihit` low for 3 cycles at PC=0x10. Expect `imemREN`=1 and `imemaddr`=0x10 held, `Adv`=0, then a single `Adv` pulse and `if_pc`=0x10.
- **Decode stall:** slot full, `id_ready`=0 for 4 cycles. Expect `imemREN`=0, `Adv`=0, slot contents unchanged. When `id_ready`=1, the next fetch issues that cycle.
- **Flush racing a hit:** `flush`=1 together with `ihit`=1 at PC=0x20. Expect `Adv`=1 and `if_valid`=0 next cycle, with no 0x20 instruction delivered. The following fetch is at the target PC.
- **Halt:** `halt`=1 with the slot full. Expect `imemREN`=0 from that cycle forever and the slot drained by `id_ready`. Only `RST` restores fetching.
- **Wrap:** accept at PC=0xFFFFFFFC. Expect `if_npc`=0x00000000.
